// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - decoder output mode encoding and inactive-level helper
package decoder_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'd0,
    DEC_THERMO   = 2'd1,
    DEC_ONEHOT_N = 2'd2,
    DEC_RSVD     = 2'd3
  } dec_mode_e;

  // Level every line takes when nothing is selected; callers replicate it to the bus width.
  function automatic logic inactive_pattern(input dec_mode_e mode);
    return (mode == DEC_ONEHOT_N);
  endfunction

endpackage

// File: rtl/decoder_n_core.sv
// rtl/decoder_n_core.sv - combinational sel/en/mode to decoded lines and range-error flag
module decoder_n_core
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  input  dec_mode_e          mode,
  output logic [NUM_OUT-1:0] dout_next,
  output logic               err_next
);

  // One extra bit so NUM_OUT == 2**SEL_W still fits in the limit.
  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_OUT);

  logic [SEL_W:0] sel_x;
  logic           in_range;

  assign sel_x    = {1'b0, sel};
  assign in_range = (sel_x < LIMIT);

  always_comb begin
    dout_next = {NUM_OUT{inactive_pattern(mode)}};
    err_next  = en && !in_range;
    if (en && in_range) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        case (mode)
          DEC_THERMO:   dout_next[i] = ((SEL_W+1)'(i) <= sel_x);
          DEC_ONEHOT_N: dout_next[i] = ((SEL_W+1)'(i) != sel_x);
          default:      dout_next[i] = ((SEL_W+1)'(i) == sel_x);
        endcase
      end
    end
  end

endmodule

// File: rtl/decoder_n_pipe.sv
// rtl/decoder_n_pipe.sv - registered N-line decoder with valid/ready handshake
// Optional saturating error counter enabled by DECODER_ERR_CNT_EN.
module decoder_n_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] dout,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);

  generate
    if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
      $error("decoder_n_pipe: NUM_OUT must be in 2..2**SEL_W");
    end
  endgenerate

  logic [NUM_OUT-1:0] dout_next;
  logic               err_next;
  logic               accept;

  decoder_n_core #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_core (
    .sel       (sel),
    .en        (en),
    .mode      (dec_mode_e'(mode)),
    .dout_next (dout_next),
    .err_next  (err_next)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A drain without a new accept only clears valid; the data bits keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= dout_next;
      err       <= err_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODER_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && err_next && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
